// File: rtl/ctrl_pkg.sv
// Shared definitions for the ID-stage control sequencer: opcodes, control-word
// bit map, FSM states and the bubble constant.
package ctrl_pkg;

  localparam int OPCODE_W = 5;
  localparam int CTRL_W   = 13;
  localparam int CNT_W    = 4;

  localparam logic [OPCODE_W-1:0] OP_ART  = 5'd0;
  localparam logic [OPCODE_W-1:0] OP_LOG  = 5'd1;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 5'd2;
  localparam logic [OPCODE_W-1:0] OP_BQE  = 5'd3;
  localparam logic [OPCODE_W-1:0] OP_BNE  = 5'd4;
  localparam logic [OPCODE_W-1:0] OP_LD   = 5'd5;
  localparam logic [OPCODE_W-1:0] OP_ST   = 5'd6;
  localparam logic [OPCODE_W-1:0] OP_CRY  = 5'd7;
  localparam logic [OPCODE_W-1:0] OP_IMM  = 5'd8;
  localparam logic [OPCODE_W-1:0] OP_CALL = 5'd9;
  localparam logic [OPCODE_W-1:0] OP_RET  = 5'd10;

  localparam int B_JUMP       = 12;
  localparam int B_RET        = 11;
  localparam int B_POP        = 10;
  localparam int B_PUSH       = 9;
  localparam int B_BRANCHTYPE = 8;
  localparam int B_REGDIST    = 7;
  localparam int B_ALUOP      = 6;
  localparam int B_ALUSRC     = 5;
  localparam int B_MEMWRITE   = 4;
  localparam int B_MEMREAD    = 3;
  localparam int B_MEMTOREG   = 2;
  localparam int B_REGWRITE   = 1;
  localparam int B_BRANCH     = 0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  function automatic logic [CTRL_W-1:0] ctrl_bit(input int idx);
    return CTRL_W'(1) << idx;
  endfunction

endpackage

// File: rtl/ctrl_seq_unit_decode.sv
// Combinational opcode decoder: head/tail control words, sequence and legality flags.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [CTRL_W-1:0]   head_word,
  output logic [CTRL_W-1:0]   tail_word,
  output logic                is_seq,
  output logic                is_legal
);

  always_comb begin
    head_word = CTRL_NOP;
    tail_word = CTRL_NOP;
    is_seq    = 1'b0;
    is_legal  = 1'b1;
    case (opcode)
      OP_ART, OP_LOG: head_word = ctrl_bit(B_REGDIST) | ctrl_bit(B_REGWRITE);
      OP_JMP:         head_word = ctrl_bit(B_JUMP);
      OP_BQE:         head_word = ctrl_bit(B_BRANCH);
      OP_BNE:         head_word = ctrl_bit(B_BRANCH) | ctrl_bit(B_BRANCHTYPE);
      OP_LD:          head_word = ctrl_bit(B_MEMREAD) | ctrl_bit(B_MEMTOREG)
                                | ctrl_bit(B_REGWRITE);
      OP_ST:          head_word = ctrl_bit(B_MEMWRITE);
      OP_CRY:         head_word = ctrl_bit(B_REGWRITE);
      OP_IMM:         head_word = ctrl_bit(B_REGDIST) | ctrl_bit(B_REGWRITE)
                                | ctrl_bit(B_ALUSRC);
      OP_CALL: begin
        head_word = ctrl_bit(B_PUSH);
        tail_word = ctrl_bit(B_JUMP);
        is_seq    = 1'b1;
      end
      OP_RET: begin
        head_word = ctrl_bit(B_POP);
        tail_word = ctrl_bit(B_RET);
        is_seq    = 1'b1;
      end
      default: is_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_seq_unit.sv
// Registered ID/EX control sequencer; CALL/RET become push/pop, bubbles, jump/ret.
// Optional undefined-opcode trap enabled with `define CTRL_ILLEGAL_TRAP_EN.
module ctrl_seq_unit #(
  parameter int OPCODE_W     = 5,
  parameter int STACK_CYCLES = 1,
  parameter int CTRL_W       = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                id_valid,
  input  logic                hazard,
  input  logic                flush,
  input  logic                illegal_clr,
  output logic                id_stall,
  output logic                ex_valid,
  output logic [CTRL_W-1:0]   ex_ctrl,
  output logic                busy,
  output logic                illegal,
  output logic [OPCODE_W-1:0] illegal_opcode
);
  import ctrl_pkg::*;

  // Handshake: id_stall=1 means ID must hold its instruction this cycle;
  // ex_valid=1 qualifies ex_ctrl as a real operation, ex_valid=0 is a bubble.

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] tail_q, tail_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic              ex_valid_q, ex_valid_d;

  logic [CTRL_W-1:0] head_word, tail_word;
  logic              is_seq, is_legal;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode    (opcode),
    .head_word (head_word),
    .tail_word (tail_word),
    .is_seq    (is_seq),
    .is_legal  (is_legal)
  );

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic trap_hit;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tail_d     = tail_q;
    ex_valid_d = 1'b0;
    ex_ctrl_d  = CTRL_NOP;
    id_stall   = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    trap_hit   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (flush) begin
          id_stall = 1'b0;
        end else if (hazard) begin
          id_stall = 1'b1;
        end else if (id_valid) begin
          if (is_seq) begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = head_word;
            cnt_d      = CNT_W'(STACK_CYCLES - 1);
            tail_d     = tail_word;
            state_d    = WAIT;
            id_stall   = 1'b1;
          end else if (is_legal) begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = head_word;
          end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            trap_hit   = 1'b1;
`else
            ex_valid_d = 1'b1;
`endif
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d    = cnt_q - 1'b1;
          id_stall = 1'b1;
        end else begin
          ex_valid_d = 1'b1;
          ex_ctrl_d  = tail_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tail_q     <= CTRL_NOP;
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= CTRL_NOP;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tail_q     <= tail_d;
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_ctrl  = ex_ctrl_q;
  assign busy     = (state_q != IDLE);

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic                illegal_q, illegal_d;
  logic [OPCODE_W-1:0] illegal_op_q, illegal_op_d;

  // A new trap in the same cycle as a clear re-arms the flag with the new opcode.
  always_comb begin
    illegal_d    = illegal_q;
    illegal_op_d = illegal_op_q;
    if (illegal_clr) begin
      illegal_d    = 1'b0;
      illegal_op_d = '0;
    end
    if (trap_hit && (!illegal_q || illegal_clr)) begin
      illegal_d    = 1'b1;
      illegal_op_d = opcode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_q    <= 1'b0;
      illegal_op_q <= '0;
    end else begin
      illegal_q    <= illegal_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  assign illegal        = illegal_q;
  assign illegal_opcode = illegal_op_q;
`else
  logic unused_illegal_clr;
  assign unused_illegal_clr = illegal_clr;
  assign illegal            = 1'b0;
  assign illegal_opcode     = '0;
`endif

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// Scoreboarded bench for ctrl_seq_unit against a queue-based schedule model.
module tb_ctrl_seq_unit;
  import ctrl_pkg::*;

  localparam int SC = 3;
  localparam int W  = 1 + 1 + 13 + 1 + 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  opcode = '0;
  logic        id_valid = 1'b0;
  logic        hazard = 1'b0;
  logic        flush = 1'b0;
  logic        illegal_clr = 1'b0;
  logic        id_stall;
  logic        ex_valid;
  logic [12:0] ex_ctrl;
  logic        busy;
  logic        illegal;
  logic [4:0]  illegal_opcode;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]  exp_q[$];
  logic [13:0]   sched[$];
  logic          m_ill;
  logic [4:0]    m_ill_op;

  ctrl_seq_unit #(.OPCODE_W(5), .STACK_CYCLES(SC), .CTRL_W(13)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .opcode         (opcode),
    .id_valid       (id_valid),
    .hazard         (hazard),
    .flush          (flush),
    .illegal_clr    (illegal_clr),
    .id_stall       (id_stall),
    .ex_valid       (ex_valid),
    .ex_ctrl        (ex_ctrl),
    .busy           (busy),
    .illegal        (illegal),
    .illegal_opcode (illegal_opcode)
  );

  always #5 clk = ~clk;

  function automatic void ref_decode(input logic [4:0] op, output bit legal,
                                     output bit seq, output logic [12:0] head,
                                     output logic [12:0] tail);
    legal = 1'b1;
    seq   = 1'b0;
    tail  = 13'h0;
    case (op)
      OP_ART, OP_LOG: head = 13'h082;
      OP_JMP:         head = 13'h1000;
      OP_BQE:         head = 13'h001;
      OP_BNE:         head = 13'h101;
      OP_LD:          head = 13'h00E;
      OP_ST:          head = 13'h010;
      OP_CRY:         head = 13'h002;
      OP_IMM:         head = 13'h0A2;
      OP_CALL: begin head = 13'h200; tail = 13'h1000; seq = 1'b1; end
      OP_RET:  begin head = 13'h400; tail = 13'h800;  seq = 1'b1; end
      default: begin head = 13'h0; legal = 1'b0; end
    endcase
  endfunction

  // One clock of stimulus; the model predicts id_stall now and the registered
  // outputs that appear after the coming edge.
  task automatic step(input logic [4:0] op, input logic v, input logic hz,
                      input logic fl, input logic clr, input logic rst);
    logic [13:0] out;
    logic        st;
    bit          legal, seq;
    logic [12:0] head, tail;
    opcode = op; id_valid = v; hazard = hz; flush = fl; illegal_clr = clr; rst_n = rst;
    #1;
    out = 14'h0;
    st  = 1'b0;
    ref_decode(op, legal, seq, head, tail);
    if (!rst) begin
      sched.delete();
      m_ill    = 1'b0;
      m_ill_op = 5'h0;
    end else begin
      if (sched.size() > 0) begin
        if (fl) sched.delete();
        else begin
          out = sched.pop_front();
          st  = (sched.size() > 0);
        end
      end else if (fl) begin
        st = 1'b0;
      end else if (hz) begin
        st = 1'b1;
      end else if (v) begin
        if (seq) begin
          out = {1'b1, head};
          for (int i = 0; i < SC - 1; i++) sched.push_back(14'h0);
          sched.push_back({1'b1, tail});
          st = 1'b1;
        end else if (legal) begin
          out = {1'b1, head};
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          if (!m_ill || clr) begin
            m_ill    = 1'b1;
            m_ill_op = op;
            clr      = 1'b0;
          end
`else
          out = {1'b1, 13'h0};
`endif
        end
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (clr) begin
        m_ill    = 1'b0;
        m_ill_op = 5'h0;
      end
`endif
      total++;
      if (id_stall !== st) begin
        bad++;
        $display("FAIL id_stall op=%0d got=%b exp=%b t=%0t", op, id_stall, st, $time);
      end
    end
    exp_q.push_back({(sched.size() > 0), out, m_ill, m_ill_op});
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    logic [W-1:0] exp_v, got_v;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {busy, ex_valid, ex_ctrl, illegal, illegal_opcode};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL ex_out got busy=%b v=%b ctrl=%h ill=%b iop=%h exp busy=%b v=%b ctrl=%h ill=%b iop=%h t=%0t",
                 got_v[20], got_v[19], got_v[18:6], got_v[5], got_v[4:0],
                 exp_v[20], exp_v[19], exp_v[18:6], exp_v[5], exp_v[4:0], $time);
      end
    end
  end

  initial begin
    logic [4:0] rop;
    m_ill = 1'b0;
    m_ill_op = 5'h0;
    @(posedge clk);
    #1;
    repeat (3) step(5'd0, 0, 0, 0, 0, 0);
    step(OP_ART, 1, 0, 0, 0, 1);
    step(OP_LD,  1, 0, 0, 0, 1);
    step(OP_ST,  1, 0, 0, 0, 1);
    step(OP_IMM, 1, 0, 0, 0, 1);
    step(5'd0, 0, 0, 0, 0, 1);
    repeat (4) step(OP_CALL, 1, 0, 0, 0, 1);
    step(OP_CRY, 1, 1, 0, 0, 1);
    repeat (4) step(OP_RET, 1, 0, 0, 0, 1);
    step(OP_LD, 1, 1, 1, 0, 1);
    step(OP_CALL, 1, 0, 0, 0, 1);
    step(OP_CALL, 1, 0, 1, 0, 1);
    step(5'd0, 0, 0, 0, 0, 1);
    step(5'd0, 0, 0, 0, 0, 1);
    step(OP_BNE, 1, 1, 0, 0, 1);
    step(OP_BNE, 1, 1, 0, 0, 1);
    step(OP_BNE, 1, 0, 0, 0, 1);
    step(OP_RET, 1, 0, 0, 0, 1);
    step(OP_RET, 1, 0, 0, 0, 0);
    step(5'd0, 0, 0, 0, 0, 1);
    step(5'd20, 1, 0, 0, 0, 1);
    step(5'd21, 1, 0, 0, 0, 1);
    step(5'd0, 0, 0, 0, 1, 1);
    step(5'd22, 1, 0, 0, 0, 1);
    step(5'd23, 1, 0, 0, 1, 1);
    step(5'd24, 1, 1, 0, 0, 1);
    step(5'd0, 0, 0, 0, 1, 1);
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) == 0) rop = 5'($urandom_range(11, 31));
      else                           rop = 5'($urandom_range(0, 10));
      step(rop, ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 8), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 99) != 0));
    end
    step(5'd0, 0, 0, 0, 0, 1);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_seq_unit.md
Name: ctrl_seq_unit

Overview:
- Registered, sequencing successor to the combinational ID-stage control decoder.
- Decodes the opcode into a fixed-order control word and registers it into the ID/EX boundary.
- Inserts bubbles on hazard/flush/invalid slots.
- Splits CALL/RET into a multi-cycle stack sequence of push/pop, STACK_CYCLES-1 bubbles, then jump/ret, stalling ID meanwhile.

Parameters:
- OPCODE_W, 5: opcode width.
- STACK_CYCLES, 1: stack access latency in cycles, legal range 1..15.
- CTRL_W, 13: control word width. Fixed; must match the package bit map.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  OPCODE_W  opcode of the instruction in ID.
- id_valid  in  1  ID slot holds a valid instruction.
- hazard  in  1  load-use hazard; bubble this cycle.
- flush  in  1  redirect; kill ID instruction and any sequence in progress.
- illegal_clr  in  1  clears the sticky illegal flag.
- id_stall  out  1  hold PC and IF/ID (combinational).
- ex_valid  out  1  ex_ctrl carries a real operation (registered).
- ex_ctrl  out  CTRL_W  registered control word.
- busy  out  1  FSM is not in IDLE (registered state decode).
- illegal  out  1  sticky undefined-opcode flag.
- illegal_opcode  out  OPCODE_W  captured undefined opcode.

Behaviour:
- Bit map: [12]jump [11]ret [10]pop [9]push [8]branchtype [7]regdist [6]aluop [5]alusrc [4]memwrite [3]memread [2]memtoreg [1]regwrite [0]branch.
- Decode by opcode:
  - ART, LOG: regdist, regwrite.
  - JMP: jump.
  - BQE: branch.
  - BNE: branch, branchtype.
  - LD: memread, memtoreg, regwrite.
  - ST: memwrite.
  - CRY: regwrite.
  - IMM: regdist, regwrite, alusrc.
  - CALL: head word push; tail word jump.
  - RET: head word pop; tail word ret.
  - aluop is never set.
- Reset: ex_ctrl=0, ex_valid=0, state=IDLE, cnt=0, illegal=0, illegal_opcode=0, busy=0.
- Latency: one cycle from decode to ex_ctrl.
- FSM states: IDLE and WAIT. Priority each cycle is flush > hazard > id_valid.
- IDLE:
  - flush: register bubble (ex_valid=0, ex_ctrl=0); id_stall=0.
  - hazard: register bubble; id_stall=1.
  - !id_valid: register bubble; id_stall=0.
  - Simple opcode: register word, ex_valid=1; id_stall=0.
  - CALL/RET: register head word, ex_valid=1; cnt<=STACK_CYCLES-1; save tail; go to WAIT; id_stall=1.
- WAIT:
  - hazard ignored.
  - cnt!=0: register bubble; cnt--; id_stall=1.
  - cnt==0: register tail word, ex_valid=1; go to IDLE; id_stall=0, so IF/ID advances on that edge.
  - flush: register bubble; go to IDLE; cnt=0; tail never issued; id_stall=0.
- Timing: CALL accepted at T gives push at T+1, bubbles T+2..T+STACK_CYCLES, jump at T+STACK_CYCLES+1.
- Undefined opcode, base build: NOP (ex_valid=1, ex_ctrl=0).
- illegal_clr has no effect without the feature. illegal and illegal_opcode read 0.
- Reset mid-sequence: returns to IDLE on the next edge; tail discarded.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: undefined opcode with id_valid, no flush, no hazard, in IDLE:
  - Registers a bubble (ex_valid=0).
  - Sets illegal and captures illegal_opcode, first occurrence only.
  - illegal_clr clears both on the next edge. A simultaneous new illegal opcode wins and sets the flag again.
- Undefined: NOP behaviour as above; trap logic absent.

Decomposition:
- Package ctrl_pkg:
  - Opcode constants, taken from the existing parameter header.
  - CTRL_W and the bit-index localparams.
  - FSM state enum {IDLE, WAIT}.
  - NOP/bubble constant.
- Sub-module ctrl_decode: purely combinational. Maps opcode to {head_word, tail_word, is_seq, is_legal}.
- ctrl_seq_unit holds the FSM, counter, ID/EX register and trap.

Test Plan:
- Reset and decode: hold rst_n=0 3 cycles, then stream ART, LD, ST, IMM with id_valid=1. Expect ex_ctrl=0x082, 0x00E, 0x010, 0x0A2 on consecutive cycles; id_stall=0 throughout.
- CALL, STACK_CYCLES=3: CALL at T. Expect ex_ctrl 0x200 at T+1, bubbles (ex_valid=0) at T+2 and T+3, 0x1000 at T+4. id_stall=1 during T..T+2, 0 at T+3. busy=1 at T+1..T+3.
- RET, STACK_CYCLES=1: RET at T. Expect 0x400 at T+1, 0x800 at T+2; id_stall=1 only at T.
- Flush priority: hazard=1 and flush=1 with LD in ID. Expect bubble, id_stall=0. Then CALL with flush at T+1 (STACK_CYCLES=2). Expect push at T+1, bubble at T+2, no jump ever, busy=0 from T+2.
- Hazard: BNE with hazard=1 for 2 cycles, then 0. Expect 2 bubbles with id_stall=1, then 0x101.
- Trap (macro on): undefined opcode at T. Expect ex_valid=0 at T+1, illegal=1, opcode captured. A second undefined opcode keeps the first capture; illegal_clr clears both next cycle. With the macro off: ex_valid=1, ex_ctrl=0.
